vjtag_debug_initiator: RTL and testbench
========================================

Name: vjtag_debug_initiator

Overview:
- Initiator side of the Nios II debug virtual-JTAG protocol.
- Takes one debug command per transaction (IR value plus a SR_WIDTH-bit data word) on a system-clock valid/ready interface and generates the virtual-JTAG strobe sequence: tck, tdi, ir_in, vs_uir/vs_cdr/vs_sdr/vs_udr, jtag_state_rti.
- Returns the tdo bits shifted out by the debug slave.
- Used as an on-chip or bench-side driver for the CPU debug slave in place of the sld_virtual_jtag_basic hub.

Parameters:
- SR_WIDTH, 38, data shift length in bits (matches the debug slave sr/jdo width).
- IR_WIDTH, 2, virtual IR width.
- TCK_DIV, 2, clk cycles per TCK half-period (>=1).

Ports:
- clk  in  1  system clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_ir  in  IR_WIDTH  virtual IR to load.
- cmd_data  in  SR_WIDTH  data shifted out on tdi, LSB first.
- rsp_valid  out  1  one-cycle pulse; response valid.
- rsp_data  out  SR_WIDTH  tdo bits captured; bit i = i-th shifted bit.
- rsp_ir_out  out  IR_WIDTH  ir_out sampled during CDR.
- tck  out  1  generated test clock.
- tdi  out  1  serial data to slave.
- tdo  in  1  serial data from slave.
- ir_in  out  IR_WIDTH  current virtual IR.
- ir_out  in  IR_WIDTH  slave status IR.
- vs_uir  out  1  update-IR state.
- vs_cdr  out  1  capture-DR state.
- vs_sdr  out  1  shift-DR state.
- vs_udr  out  1  update-DR state.
- jtag_state_rti  out  1  run-test-idle.

Behaviour:
Reset values:
- tck, tdi, all vs_* strobes, rsp_valid = 0.
- ir_in, rsp_data, rsp_ir_out = 0.
- jtag_state_rti = 1; cmd_ready = 1; state = IDLE; ir_known = 0.

States: IDLE, UIR, CDR, SDR, UDR, RTI.
- IDLE: tck held 0.
- Every other state lasts exactly one TCK period per bit, except SDR, which lasts SR_WIDTH periods.
- Period structure: each period is 2*TCK_DIV clk cycles. tck is 0 for the first TCK_DIV cycles and 1 for the last TCK_DIV cycles.
- Outputs change only on the clk edge where a period starts (tck falling or leaving IDLE). The slave samples them on tck rising.

Accept and UIR:
- A command is accepted when cmd_valid && cmd_ready (cycle 0).
- cmd_ir and cmd_data are latched. cmd_ready drops in cycle 1.
- Next state is UIR, or CDR directly when ir_known && cmd_ir == ir_in (UIR skipped).
- UIR: vs_uir=1; ir_in = latched cmd_ir, held until the next UIR. Sets ir_known=1.

Remaining states:
- CDR: vs_cdr=1. ir_out is sampled into rsp_ir_out on the tck rising clk cycle.
- SDR: vs_sdr=1; tdi = shift[0].
  - On each tck rising clk cycle: shift <= {tdo, shift[SR_WIDTH-1:1]}.
  - A bit counter counts 0..SR_WIDTH-1; after the last period the state moves to UDR.
- UDR: vs_udr=1; tdi=0.
- RTI: jtag_state_rti=1 (it is 0 in UIR..UDR).
  - At the end of the period: rsp_data <= shift; rsp_valid=1 for exactly one cycle.
  - In the same cycle the state returns to IDLE and cmd_ready=1.
  - jtag_state_rti stays 1 in IDLE.

Latency and ordering:
- Periods per command: P = SR_WIDTH+4 (SR_WIDTH+3 if UIR skipped).
- rsp_valid is asserted in cycle 2*TCK_DIV*P+1 after accept.
- cmd_valid is ignored while not IDLE; cmd_* may change freely after accept.
- Exactly one strobe of vs_uir/vs_cdr/vs_sdr/vs_udr is high outside IDLE/RTI; none are high in IDLE/RTI.
- A new command accepted in the rsp_valid cycle starts its own UIR/CDR period in the next cycle. No back-to-back gap beyond that.

Reset mid-operation:
- All outputs return to reset values in the next cycle; tck forced 0.
- No rsp_valid is produced for the aborted command; ir_known=0, so the next command always issues UIR.

Test Plan:
- TCK_DIV=2, SR_WIDTH=38, tdo tied to tdi (loopback); cmd_ir=2'b01, cmd_data=38'h2A_5A5A_5A5A accepted at cycle 0 -> rsp_valid at cycle 169 with rsp_data=38'h2A_5A5A_5A5A; vs_uir high cycles 1-4, vs_cdr 5-8, vs_sdr 9-160, vs_udr 161-164; ir_in=2'b01 from cycle 1.
- Same command repeated immediately after rsp_valid -> vs_uir never asserts; rsp_valid 165 cycles after accept; tck shows 41 rising edges.
- tdo tied 1, ir_out=2'b10, cmd_data=0 -> rsp_data=38'h3F_FFFF_FFFF, rsp_ir_out=2'b10; tdi 0 on all 38 SDR rising edges.
- Slave model driving a 38-bit pattern LSB-first on tdo -> rsp_data equals the pattern; count exactly 38 tck rising edges while vs_sdr=1.
- reset asserted at cycle 60 (mid-SDR) -> next cycle: tck=0, strobes 0, jtag_state_rti=1, cmd_ready=1, no rsp_valid; next command with the same cmd_ir still issues vs_uir.
- cmd_valid held high with changing cmd_data during a transaction -> only the first value is shifted; second command is accepted only in the rsp_valid cycle.

Source files
------------

// File: rtl/vjtag_debug_initiator.sv
// Virtual-JTAG debug initiator: turns one IR/DR command into the
// hub strobe sequence (UIR, CDR, SDR, UDR, RTI) and returns tdo.
module vjtag_debug_initiator #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    localparam int CW = (2 * TCK_DIV > 2) ? $clog2(2 * TCK_DIV) : 1;
    localparam int BW = (SR_WIDTH > 2) ? $clog2(SR_WIDTH) : 1;
    localparam logic [CW-1:0] RISE = CW'(TCK_DIV - 1);
    localparam logic [CW-1:0] PEND = CW'(2 * TCK_DIV - 1);
    localparam logic [BW-1:0] LAST = BW'(SR_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        UIR,
        CDR,
        SDR,
        UDR,
        RTI
    } state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [BW-1:0]       bit_cnt, bit_cnt_n;
    logic [SR_WIDTH-1:0] shift, shift_n;
    logic                ir_known, ir_known_n;
    logic [IR_WIDTH-1:0] ir_in_n;
    logic                tck_n, tdi_n;
    logic                rsp_valid_n;
    logic [SR_WIDTH-1:0] rsp_data_n;
    logic [IR_WIDTH-1:0] rsp_ir_out_n;
    logic                start;

    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        ir_known_n   = ir_known;
        ir_in_n      = ir_in;
        tck_n        = tck;
        tdi_n        = tdi;
        rsp_valid_n  = 1'b0;
        rsp_data_n   = rsp_data;
        rsp_ir_out_n = rsp_ir_out;
        start        = 1'b0;

        if (state == IDLE) begin
            if (cmd_valid) begin
                start     = 1'b1;
                cnt_n     = '0;
                bit_cnt_n = '0;
                shift_n   = cmd_data;
                // The slave keeps its IR, so an unchanged IR skips UIR.
                if (ir_known && cmd_ir == ir_in) begin
                    state_n = CDR;
                end else begin
                    state_n    = UIR;
                    ir_in_n    = cmd_ir;
                    ir_known_n = 1'b1;
                end
            end
        end else if (cnt == PEND) begin
            cnt_n = '0;
            tck_n = 1'b0;
            start = 1'b1;
            unique case (state)
                UIR: state_n = CDR;
                CDR: state_n = SDR;
                SDR: begin
                    if (bit_cnt == LAST) begin
                        state_n = UDR;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                UDR: state_n = RTI;
                RTI: begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = shift;
                end
                default: state_n = IDLE;
            endcase
        end else begin
            cnt_n = cnt + 1'b1;
            // Sample on the edge that raises tck, like the slave does.
            if (cnt == RISE) begin
                tck_n = 1'b1;
                if (state == CDR) begin
                    rsp_ir_out_n = ir_out;
                end
                if (state == SDR) begin
                    shift_n = {tdo, shift[SR_WIDTH-1:1]};
                end
            end
        end

        if (start) begin
            tdi_n = (state_n == SDR) ? shift[0] : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_cnt        <= '0;
            shift          <= '0;
            ir_known       <= 1'b0;
            ir_in          <= '0;
            tck            <= 1'b0;
            tdi            <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_ir_out     <= '0;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b1;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            bit_cnt        <= bit_cnt_n;
            shift          <= shift_n;
            ir_known       <= ir_known_n;
            ir_in          <= ir_in_n;
            tck            <= tck_n;
            tdi            <= tdi_n;
            rsp_valid      <= rsp_valid_n;
            rsp_data       <= rsp_data_n;
            rsp_ir_out     <= rsp_ir_out_n;
            vs_uir         <= (state_n == UIR);
            vs_cdr         <= (state_n == CDR);
            vs_sdr         <= (state_n == SDR);
            vs_udr         <= (state_n == UDR);
            jtag_state_rti <= (state_n == IDLE) || (state_n == RTI);
        end
    end

endmodule

// File: tb/tb_vjtag_debug_initiator.sv
// Randomized scoreboard bench for vjtag_debug_initiator with a
// behavioural slave on tdo (loopback, constant one, or pattern).
module tb_vjtag_debug_initiator;

    localparam int SRW = 38;
    localparam int IRW = 2;
    localparam int TD  = 2;
    localparam int L   = 2 * TD;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [IRW-1:0] cmd_ir = '0;
    logic [SRW-1:0] cmd_data = '0;
    logic           rsp_valid;
    logic [SRW-1:0] rsp_data;
    logic [IRW-1:0] rsp_ir_out;
    logic           tck, tdi, tdo;
    logic [IRW-1:0] ir_in;
    logic [IRW-1:0] ir_out = '0;
    logic           vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;

    int             mode = 0;
    logic [SRW-1:0] pat = '0;
    logic           tdo_drv = 1'b0;

    assign tdo = (mode == 0) ? tdi : tdo_drv;

    vjtag_debug_initiator #(
        .SR_WIDTH(SRW), .IR_WIDTH(IRW), .TCK_DIV(TD)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_ir_out(rsp_ir_out),
        .tck(tck), .tdi(tdi), .tdo(tdo),
        .ir_in(ir_in), .ir_out(ir_out),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr),
        .vs_sdr(vs_sdr), .vs_udr(vs_udr),
        .jtag_state_rti(jtag_state_rti)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SRW-1:0] rnd();
        return SRW'({$urandom(), $urandom()});
    endfunction

    typedef struct {
        int             acc;
        int             lat;
        bit             uir;
        logic [IRW-1:0] ir;
        logic [IRW-1:0] iro;
        logic [SRW-1:0] cmd;
        logic [SRW-1:0] rsp;
    } exp_t;

    exp_t q[$];

    // Slave: presents bit i of pat on tdo before the i-th SDR tck rise.
    int   slv_idx = 0;
    logic slv_tck_q = 1'b0;
    always @(negedge clk) begin
        if (vs_cdr) slv_idx = 0;
        else if (vs_sdr && tck && !slv_tck_q) slv_idx++;
        slv_tck_q = tck;
        if (mode == 1) tdo_drv = 1'b1;
        else if (slv_idx < SRW) tdo_drv = pat[slv_idx];
        else tdo_drv = 1'b0;
    end

    bit             mon_en = 1'b0;
    logic           tck_q = 1'b0;
    int             rises, sdr_rises;
    int             uir_n, cdr_n, sdr_n, udr_n;
    int             uir_f, cdr_f, sdr_f, udr_f;
    logic [SRW-1:0] tdi_cap;

    task automatic clr();
        rises = 0; sdr_rises = 0;
        uir_n = 0; cdr_n = 0; sdr_n = 0; udr_n = 0;
        uir_f = -1; cdr_f = -1; sdr_f = -1; udr_f = -1;
        tdi_cap = '0;
    endtask

    always @(negedge clk) begin
        logic rise;
        int   rel;
        int   base;
        rise  = tck && !tck_q;
        tck_q = tck;
        if (mon_en && !reset) begin
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    base = 1 + (e.uir ? L : 0);
                    check("rsp_data", rsp_data, e.rsp);
                    check("rsp_ir_out", rsp_ir_out, e.iro);
                    check("latency", cyc - e.acc, e.lat);
                    check("ir_in", ir_in, e.ir);
                    check("tck_rises", rises, SRW + 3 + int'(e.uir));
                    check("sdr_rises", sdr_rises, SRW);
                    check("tdi_bits", tdi_cap, e.cmd);
                    check("uir_cycles", uir_n, e.uir ? L : 0);
                    if (e.uir) check("uir_first", uir_f, 1);
                    check("cdr_first", cdr_f, base);
                    check("cdr_cycles", cdr_n, L);
                    check("sdr_first", sdr_f, base + L);
                    check("sdr_cycles", sdr_n, SRW * L);
                    check("udr_first", udr_f, base + L + SRW * L);
                    check("udr_cycles", udr_n, L);
                end
                clr();
            end else if (cmd_ready) begin
                check("idle_outputs",
                      {tck, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti},
                      6'b000001);
                clr();
            end else if (q.size() > 0) begin
                rel = cyc - q[0].acc;
                check("one_state",
                      $countones({vs_uir, vs_cdr, vs_sdr, vs_udr,
                                  jtag_state_rti}), 1);
                if (vs_uir) begin if (uir_n == 0) uir_f = rel; uir_n++; end
                if (vs_cdr) begin if (cdr_n == 0) cdr_f = rel; cdr_n++; end
                if (vs_sdr) begin if (sdr_n == 0) sdr_f = rel; sdr_n++; end
                if (vs_udr) begin if (udr_n == 0) udr_f = rel; udr_n++; end
                if (rise) begin
                    rises++;
                    if (vs_sdr) begin
                        if (sdr_rises < SRW) tdi_cap[sdr_rises] = tdi;
                        sdr_rises++;
                    end
                end
            end
        end
    end

    // Reference model state: which IR the slave is known to hold.
    bit             known = 1'b0;
    logic [IRW-1:0] known_ir = '0;
    int             prev_rsp = -1;

    task automatic send(input logic [IRW-1:0] ir, input logic [SRW-1:0] d,
                        input logic [IRW-1:0] iro, input bit keep,
                        output int acc);
        exp_t e;
        int   w;
        w   = 0;
        acc = -1;
        @(negedge clk);
        while (!cmd_ready && w < 4000) begin
            if (keep) cmd_data = rnd();
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        if (prev_rsp >= 0) check("b2b_accept", cyc, prev_rsp);
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_data  = d;
        ir_out    = iro;
        pat       = rnd();
        e.acc  = cyc;
        e.uir  = !known || (ir != known_ir);
        known    = 1'b1;
        known_ir = ir;
        e.lat  = L * (SRW + 3 + int'(e.uir)) + 1;
        e.ir   = ir;
        e.iro  = iro;
        e.cmd  = d;
        e.rsp  = (mode == 0) ? d : (mode == 1) ? '1 : pat;
        q.push_back(e);
        prev_rsp = e.acc + e.lat;
        acc      = e.acc;
        @(negedge clk);
        cmd_valid = keep;
        if (keep) cmd_data = rnd();
    endtask

    task automatic drain();
        int w;
        w = 0;
        cmd_valid = 1'b0;
        while (q.size() > 0 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        if (q.size() > 0) check("drain_timeout", q.size(), 0);
        prev_rsp = -1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int acc;
        clr();
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_rti", jtag_state_rti, 1);
        check("rst_tck_tdi", {tck, tdi}, 0);
        check("rst_strobes", {vs_uir, vs_cdr, vs_sdr, vs_udr}, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_regs", {ir_in, rsp_ir_out, rsp_data}, 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        mode = 0;
        send(2'b01, 38'h2A_5A5A_5A5A, 2'($urandom), 1'b0, acc);
        send(2'b01, 38'h2A_5A5A_5A5A, 2'($urandom), 1'b0, acc);
        for (int i = 0; i < 6; i++)
            send(2'($urandom), rnd(), 2'($urandom), 1'b0, acc);
        drain();

        mode = 1;
        send(2'b01, '0, 2'b10, 1'b0, acc);
        for (int i = 0; i < 3; i++)
            send(2'($urandom), rnd(), 2'($urandom), 1'b0, acc);
        drain();

        mode = 2;
        for (int i = 0; i < 5; i++)
            send(2'($urandom), rnd(), 2'($urandom), 1'b0, acc);
        drain();

        mode = 0;
        send(2'b01, rnd(), 2'($urandom), 1'b0, acc);
        while (cyc < acc + 60) @(negedge clk);
        reset = 1'b1;
        q.delete();
        known    = 1'b0;
        prev_rsp = -1;
        @(negedge clk);
        check("mid_rst_tck", tck, 0);
        check("mid_rst_strobes", {vs_uir, vs_cdr, vs_sdr, vs_udr}, 0);
        check("mid_rst_rti", jtag_state_rti, 1);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_ir_in", ir_in, 0);
        reset = 1'b0;
        send(2'b01, rnd(), 2'($urandom), 1'b0, acc);
        drain();

        for (int i = 0; i < 4; i++)
            send(2'($urandom), rnd(), 2'($urandom), 1'b1, acc);
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
